// File: rtl/add_sub_dispatcher.sv
// add_sub_dispatcher: round-robin issue of NUM_REQ reservation-station
// requests into one shared add_sub_unit, with credit-based flow control.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_*                   flattened per-requester request bundles
//   req_ready               one-hot (or zero) accept back to requesters
//   unit_*                  registered issue bundle to add_sub_unit
//   unit_output_valid/ready monitored result handshake (retire)
//   credits                 free in-flight slots
//   last_grant              index of most recent grant
// Optional macro ADD_SUB_DISPATCHER_PERF_EN adds perf_issue_count and
// perf_stall_count (32-bit wrapping counters).

package add_sub_pkg;
    typedef struct packed {
        logic subtract;
        logic use_carry_in;
        logic carry_in_one;
        logic invert_op1;
        logic set_ca;
        logic set_ov;
        logic record_cr;
        logic sign_ext_32;
    } add_sub_decode_t;
endpackage

module add_sub_dispatcher
    import add_sub_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int RS_ID_WIDTH     = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int LG_W            = $clog2(NUM_REQ),
    parameter int CW              = $clog2(MAX_OUTSTANDING + 1),
    parameter int CTRL_W          = $bits(add_sub_decode_t)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*RS_ID_WIDTH-1:0] req_rs_id,
    input  logic [NUM_REQ*5-1:0]           req_result_reg_addr,
    input  logic [NUM_REQ*32-1:0]          req_op1,
    input  logic [NUM_REQ*32-1:0]          req_op2,
    input  logic [NUM_REQ*32-1:0]          req_xer,
    input  logic [NUM_REQ*CTRL_W-1:0]      req_control,
    output logic                           unit_input_valid,
    input  logic                           unit_input_ready,
    output logic [RS_ID_WIDTH-1:0]         unit_rs_id,
    output logic [4:0]                     unit_result_reg_addr,
    output logic [31:0]                    unit_op1,
    output logic [31:0]                    unit_op2,
    output logic [31:0]                    unit_xer,
    output add_sub_decode_t                unit_control,
    input  logic                           unit_output_valid,
    input  logic                           unit_output_ready,
    output logic [CW-1:0]                  credits,
    output logic [LG_W-1:0]                last_grant
`ifdef ADD_SUB_DISPATCHER_PERF_EN
    ,
    output logic [31:0]                    perf_issue_count,
    output logic [31:0]                    perf_stall_count
`endif
);

    localparam logic [CW:0]   CRED_MAX = (CW+1)'(MAX_OUTSTANDING);
    localparam logic [LG_W-1:0] LG_RST = LG_W'(NUM_REQ - 1);

    logic            slot_free;
    logic            accept;
    logic            retire;
    logic            grant_found;
    logic [LG_W-1:0] grant_idx;
    logic [CW:0]     cred_sum;
    logic [CW-1:0]   credits_next;

    assign slot_free = ~unit_input_valid | unit_input_ready;
    assign retire    = unit_output_valid & unit_output_ready;

    // Scan from the requester after the last winner, wrapping once.
    always_comb begin : arb
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = LG_W'(idx);
            end
        end
    end

    // rst_n gates accept so no requester sees a handshake during reset.
    assign accept = rst_n & slot_free & (credits != '0) & grant_found;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    // Retire at full credits is ignored by clamping the sum.
    always_comb begin
        cred_sum = {1'b0, credits} + (CW+1)'(retire) - (CW+1)'(accept);
        if (cred_sum > CRED_MAX) credits_next = CRED_MAX[CW-1:0];
        else                     credits_next = cred_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits    <= CRED_MAX[CW-1:0];
            last_grant <= LG_RST;
        end else begin
            credits <= credits_next;
            if (accept) last_grant <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_input_valid     <= 1'b0;
            unit_rs_id           <= '0;
            unit_result_reg_addr <= '0;
            unit_op1             <= '0;
            unit_op2             <= '0;
            unit_xer             <= '0;
            unit_control         <= '0;
        end else if (accept) begin
            unit_input_valid     <= 1'b1;
            unit_rs_id           <= req_rs_id[grant_idx*RS_ID_WIDTH +: RS_ID_WIDTH];
            unit_result_reg_addr <= req_result_reg_addr[grant_idx*5 +: 5];
            unit_op1             <= req_op1[grant_idx*32 +: 32];
            unit_op2             <= req_op2[grant_idx*32 +: 32];
            unit_xer             <= req_xer[grant_idx*32 +: 32];
            unit_control         <= add_sub_decode_t'(req_control[grant_idx*CTRL_W +: CTRL_W]);
        end else if (unit_input_ready) begin
            unit_input_valid <= 1'b0;
        end
    end

`ifdef ADD_SUB_DISPATCHER_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_count <= '0;
            perf_stall_count <= '0;
        end else begin
            if (accept) perf_issue_count <= perf_issue_count + 32'd1;
            if (|req_valid && !accept) perf_stall_count <= perf_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_add_sub_dispatcher.sv
// tb_add_sub_dispatcher: table-driven, directed and random checks of
// add_sub_dispatcher against a cycle-level reference model.

module tb_add_sub_dispatcher;
    import add_sub_pkg::*;

    localparam int N    = 4;
    localparam int RW   = 5;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);
    localparam int LGW  = $clog2(N);
    localparam int CTW  = $bits(add_sub_decode_t);
    localparam int DW   = RW + 5 + 96 + CTW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*RW-1:0]      req_rs_id;
    logic [N*5-1:0]       req_result_reg_addr;
    logic [N*32-1:0]      req_op1;
    logic [N*32-1:0]      req_op2;
    logic [N*32-1:0]      req_xer;
    logic [N*CTW-1:0]     req_control;
    logic                 unit_input_valid;
    logic                 unit_input_ready;
    logic [RW-1:0]        unit_rs_id;
    logic [4:0]           unit_result_reg_addr;
    logic [31:0]          unit_op1;
    logic [31:0]          unit_op2;
    logic [31:0]          unit_xer;
    add_sub_decode_t      unit_control;
    logic                 unit_output_valid;
    logic                 unit_output_ready;
    logic [CW-1:0]        credits;
    logic [LGW-1:0]       last_grant;
`ifdef ADD_SUB_DISPATCHER_PERF_EN
    logic [31:0]          perf_issue_count;
    logic [31:0]          perf_stall_count;
`endif

    add_sub_dispatcher #(
        .NUM_REQ(N), .RS_ID_WIDTH(RW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs_id(req_rs_id), .req_result_reg_addr(req_result_reg_addr),
        .req_op1(req_op1), .req_op2(req_op2), .req_xer(req_xer),
        .req_control(req_control),
        .unit_input_valid(unit_input_valid),
        .unit_input_ready(unit_input_ready),
        .unit_rs_id(unit_rs_id),
        .unit_result_reg_addr(unit_result_reg_addr),
        .unit_op1(unit_op1), .unit_op2(unit_op2), .unit_xer(unit_xer),
        .unit_control(unit_control),
        .unit_output_valid(unit_output_valid),
        .unit_output_ready(unit_output_ready),
        .credits(credits), .last_grant(last_grant)
`ifdef ADD_SUB_DISPATCHER_PERF_EN
        , .perf_issue_count(perf_issue_count)
        , .perf_stall_count(perf_stall_count)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] dut_data;
    assign dut_data = {unit_rs_id, unit_result_reg_addr, unit_op1,
                       unit_op2, unit_xer, unit_control};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one staging slot plus an in-flight budget.
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_credits;
    int            m_lg;
    int            m_issue;
    int            m_stall;

    function automatic void m_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_credits = MAXO;
        m_lg      = N - 1;
        m_issue   = 0;
        m_stall   = 0;
    endfunction

    function automatic int m_pick();
        for (int d = 0; d < N; d++)
            if (req_valid[(m_lg + 1 + d) % N]) return (m_lg + 1 + d) % N;
        return -1;
    endfunction

    function automatic bit m_accept();
        return (!m_valid || unit_input_ready) && m_credits > 0 &&
               req_valid != '0;
    endfunction

    function automatic logic [DW-1:0] m_slice(input int g);
        return {req_rs_id[g*RW +: RW], req_result_reg_addr[g*5 +: 5],
                req_op1[g*32 +: 32], req_op2[g*32 +: 32],
                req_xer[g*32 +: 32], req_control[g*CTW +: CTW]};
    endfunction

    task automatic set_in(input logic [N-1:0] rv, input logic uir,
                          input logic ret);
        req_valid         = rv;
        unit_input_ready  = uir;
        unit_output_valid = ret;
        unit_output_ready = ret;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_rs_id[i*RW +: RW]          = RW'($urandom);
            req_result_reg_addr[i*5 +: 5]  = 5'($urandom);
            req_op1[i*32 +: 32]            = $urandom;
            req_op2[i*32 +: 32]            = $urandom;
            req_xer[i*32 +: 32]            = $urandom;
            req_control[i*CTW +: CTW]      = CTW'($urandom);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle();
        bit            acc;
        int            g;
        logic [N-1:0]  er;
        logic [DW-1:0] nd;
        bit            ret;
        #1;
        acc = m_accept();
        g   = m_pick();
        er  = '0;
        if (acc) er[g] = 1'b1;
        nd  = acc ? m_slice(g) : '0;
        ret = unit_output_valid && unit_output_ready;
        chk("req_ready", req_ready, er);
        chk("unit_input_valid", unit_input_valid, m_valid);
        chk("credits", credits, m_credits);
        chk("last_grant", last_grant, m_lg);
        if (m_valid) chk("unit_data", dut_data, m_data);
`ifdef ADD_SUB_DISPATCHER_PERF_EN
        chk("perf_issue", perf_issue_count, m_issue);
        chk("perf_stall", perf_stall_count, m_stall);
`endif
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_data  = nd;
            m_lg    = g;
            m_issue++;
        end else if (unit_input_ready) begin
            m_valid = 1'b0;
        end
        if (req_valid != '0 && !acc) m_stall++;
        m_credits = m_credits - int'(acc) + int'(ret);
        if (m_credits > MAXO) m_credits = MAXO;
        @(negedge clk);
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic         uir;
        logic         ret;
        int           exp_g;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [N-1:0]  er;
        logic [DW-1:0] held;
        int            acc_cnt;

        tbl[0] = '{4'b1111, 1'b1, 1'b0, 0};
        tbl[1] = '{4'b1111, 1'b1, 1'b1, 1};
        tbl[2] = '{4'b1111, 1'b1, 1'b1, 2};
        tbl[3] = '{4'b1111, 1'b1, 1'b1, 3};
        tbl[4] = '{4'b1111, 1'b1, 1'b1, 0};
        tbl[5] = '{4'b1111, 1'b1, 1'b1, 1};
        tbl[6] = '{4'b1111, 1'b1, 1'b1, 2};
        tbl[7] = '{4'b1111, 1'b1, 1'b1, 3};
        tbl[8] = '{4'b0100, 1'b1, 1'b1, 2};
        tbl[9] = '{4'b0000, 1'b1, 1'b1, -1};

        rst_n = 1'b0;
        set_in(4'b1111, 1'b1, 1'b0);
        rand_data();
        m_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", unit_input_valid, 1'b0);
        chk("rst_data", dut_data, '0);
        chk("rst_credits", credits, MAXO);
        chk("rst_last_grant", last_grant, N - 1);
        chk("rst_req_ready", req_ready, '0);
        rst_n = 1'b1;

        // Round-robin order, then a lone requester after pointer = 3.
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rv, tbl[i].uir, tbl[i].ret);
            rand_data();
            #1;
            er = '0;
            if (tbl[i].exp_g >= 0) er[tbl[i].exp_g] = 1'b1;
            chk("tbl_ready", req_ready, er);
            cycle();
            if (tbl[i].exp_g >= 0) begin
                chk("tbl_rs_id", unit_rs_id,
                    req_rs_id[tbl[i].exp_g*RW +: RW]);
                chk("tbl_last_grant", last_grant, tbl[i].exp_g);
            end
        end
        chk("tbl_credits_end", credits, MAXO);

        // Credit exhaustion with no retire.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(4'b1111, 1'b1, 1'b0);
            rand_data();
            #1;
            if (req_ready != '0) acc_cnt++;
            cycle();
        end
        chk("exhaust_accepts", acc_cnt, MAXO);
        chk("exhaust_credits", credits, 0);
        #1;
        chk("exhaust_ready", req_ready, '0);
        @(negedge clk);
        set_in(4'b1111, 1'b1, 1'b1);
        #1;
        chk("retire_no_accept", req_ready, '0);
        cycle();
        chk("retire_credit", credits, 1);
        set_in(4'b1111, 1'b1, 1'b0);
        rand_data();
        #1;
        chk("post_retire_accept", req_ready != '0, 1'b1);
        cycle();

        // Back-pressure: outputs hold, no accept, then same-cycle reload.
        held = dut_data;
        for (int i = 0; i < 3; i++) begin
            set_in(4'b1111, 1'b0, 1'b1);
            rand_data();
            #1;
            chk("stall_ready", req_ready, '0);
            cycle();
            chk("stall_hold", dut_data, held);
            chk("stall_valid", unit_input_valid, 1'b1);
        end
        set_in(4'b1111, 1'b1, 1'b0);
        rand_data();
        #1;
        chk("reload_ready", req_ready != '0, 1'b1);
        cycle();
        chk("pre_both_credits", credits, 2);

        // Accept and retire together leave credits unchanged.
        set_in(4'b1111, 1'b1, 1'b1);
        rand_data();
        cycle();
        chk("both_credits", credits, 2);

        // Random traffic; retire only while something is in flight.
        for (int i = 0; i < 400; i++) begin
            req_valid         = N'($urandom);
            unit_input_ready  = ($urandom_range(0, 3) != 0);
            unit_output_valid = ($urandom_range(0, 2) != 0);
            unit_output_ready = ($urandom_range(0, 3) != 0);
            if (m_credits == MAXO) unit_output_valid = 1'b0;
            rand_data();
            cycle();
        end

        // Drain, then leave credits=1 with the slot occupied.
        for (int i = 0; i < 20 && m_credits < MAXO; i++) begin
            set_in('0, 1'b1, 1'b1);
            cycle();
        end
        for (int i = 0; i < MAXO - 1; i++) begin
            set_in(4'b1111, 1'b1, 1'b0);
            rand_data();
            cycle();
        end
        chk("pre_rst_credits", credits, 1);
        chk("pre_rst_valid", unit_input_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", unit_input_valid, 1'b0);
        chk("async_credits", credits, MAXO);
        chk("async_last_grant", last_grant, N - 1);
        chk("async_ready", req_ready, '0);
`ifdef ADD_SUB_DISPATCHER_PERF_EN
        chk("async_perf_issue", perf_issue_count, 0);
        chk("async_perf_stall", perf_stall_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        set_in(4'b0010, 1'b1, 1'b0);
        rand_data();
        cycle();
        chk("post_rst_grant", last_grant, 1);
        set_in('0, 1'b1, 1'b0);
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
